apb_i2c_requester: RTL and testbench
====================================

# apb_i2c_requester

APB requester that drives the APB slave port of the APB-to-I2C core from a simple valid/ready command stream. It turns each command into one APB transfer (SETUP then ACCESS), waits for PREADY, and returns read data, PSLVERR and timeout status on a valid/ready response stream. It sits between a local controller (CPU-less test sequencer or DMA) and the I2C core, and aborts transfers the slave never completes.

## Interface
Parameters:
- ADDR_W, 32, APB address width
- DATA_W, 32, APB data width
- TIMEOUT, 16, max ACCESS-phase wait cycles with PREADY low before abort; 0 disables the timeout
- TO_W, 8, timeout counter width; TIMEOUT must be < 2**TO_W

Ports:
- PCLK  in  1  clock; all logic rises on PCLK
- PRESET  in  1  asynchronous, active-high reset
- CMD_VALID  in  1  command offered
- CMD_READY  out  1  command accepted when both high
- CMD_WRITE  in  1  1 = write, 0 = read
- CMD_ADDR  in  ADDR_W  transfer address
- CMD_WDATA  in  DATA_W  write data (ignored for reads)
- RSP_VALID  out  1  response available
- RSP_READY  in  1  response consumed when both high
- RSP_RDATA  out  DATA_W  read data; 0 for writes and timeouts
- RSP_ERROR  out  1  PSLVERR sampled at completion, or 1 on timeout
- RSP_TIMEOUT  out  1  transfer aborted by timeout
- PSELx, PENABLE, PWRITE  out  1  APB control
- PADDR  out  ADDR_W, PWDATA  out  DATA_W  APB address/data
- PRDATA  in  DATA_W, PREADY  in  1, PSLVERR  in  1  APB slave returns

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: CMD_READY=1, PSELx=0, PENABLE=0. On CMD_VALID: register CMD_WRITE/ADDR/WDATA into PWRITE/PADDR/PWDATA, go to SETUP.
- SETUP: PSELx=1, PENABLE=0, for exactly one cycle, then go to ACCESS; clear the wait counter.
- ACCESS: PSELx=1, PENABLE=1.
  - If PREADY=1: capture PRDATA (reads only; writes capture 0) and PSLVERR into RSP_RDATA/RSP_ERROR, set RSP_TIMEOUT=0, go to RESP.
  - If PREADY=0: increment the wait counter. When TIMEOUT≠0 and the counter equals TIMEOUT: RSP_ERROR=1, RSP_TIMEOUT=1, RSP_RDATA=0, go to RESP.
- RESP: PSELx=0, PENABLE=0, RSP_VALID=1, with response fields held stable. On RSP_READY, go to IDLE.
- CMD_READY is high only in IDLE. Exactly one outstanding transfer at a time.
- PADDR, PWDATA and PWRITE stay constant from SETUP through the end of ACCESS. They hold their last value while idle and never glitch to X.
- PSLVERR and PRDATA are ignored in every cycle except an ACCESS cycle with PREADY=1.

## Timing
- Reset (asynchronous, immediate): state=IDLE. All outputs 0 except CMD_READY=1 after the reset releases. Counter=0.
- Reset mid-transfer drops PSELx/PENABLE at once and produces no response.
- Zero-wait-state slave: accept in cycle 0, SETUP in cycle 1, ACCESS with PREADY in cycle 2, RSP_VALID in cycle 3. The next command can be accepted in cycle 4 if RSP_READY is high in cycle 3, giving 4 cycles per transfer.
- Each PREADY-low ACCESS cycle adds one cycle of latency.
- Timeout: ACCESS lasts exactly TIMEOUT cycles with PREADY low, then RESP follows. If PREADY rises in the same cycle the count would expire, completion wins (normal response).
- RSP_READY held low stalls in RESP indefinitely. No new command is accepted and the APB bus stays idle.

## Structure
- apb_i2c_pkg holds:
  - the state enum (IDLE/SETUP/ACCESS/RESP)
  - the I2C core register offsets: TX=0, RX=4, CONFIG=8, TIMEOUT=12
  - the response struct type (rdata, error, timeout)
- One sub-module, apb_wait_timer: a clear/increment counter with a terminal-count compare against TIMEOUT.

## Test plan
- Write to CONFIG: command write, addr 8, data 0x0000_2A5C against the I2C core. Required: one SETUP and one ACCESS cycle; response RDATA=0, ERROR=0, TIMEOUT=0; core config register reads back 0x2A5C.
- Read RX: command read, addr 4, with the core's RX data = 0xDEAD_BEEF. Required: RSP_RDATA=0xDEADBEEF, RESP asserted 3 cycles after accept.
- Unmapped address: command read, addr 0x10 (slave never raises PREADY), TIMEOUT=16. Required: exactly 16 ACCESS cycles, then RSP_ERROR=1, RSP_TIMEOUT=1, RDATA=0; PSELx low in the RESP cycle.
- Slave error: write to addr 0 with PSLVERR=1. Required: ERROR=1, TIMEOUT=0; PSLVERR forced to 1 outside the PREADY cycle has no effect.
- Backpressure: hold RSP_READY low for 10 cycles with CMD_VALID held high. Required: CMD_READY=0, PSELx=0 and the response stable throughout; the next command is accepted 1 cycle after RSP_READY rises.
- Reset in ACCESS: assert PRESET mid-wait. Required: PSELx/PENABLE go to 0 before the next clock edge, no RSP_VALID is issued, and the block is in IDLE after release.

Source files
------------

// File: rtl/apb_i2c_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : apb_i2c_pkg
//  Description : Shared types and constants for the APB requester that drives
//                the APB-to-I2C core: FSM state encoding, the core's register
//                offsets and the response record returned to the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package apb_i2c_pkg;

    // Requester FSM states, 2-bit explicit encoding.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_RESP   = 2'd3
    } apb_state_e;

    // Register map of the APB-to-I2C core (byte offsets).
    localparam int unsigned C_REG_TX      = 0;
    localparam int unsigned C_REG_RX      = 4;
    localparam int unsigned C_REG_CONFIG  = 8;
    localparam int unsigned C_REG_TIMEOUT = 12;

    // Width of the read-data field held in the response record. The requester
    // supports DATA_W up to this width; narrower buses are zero-extended.
    localparam int C_RSP_RDATA_W = 32;

    typedef struct packed {
        logic [C_RSP_RDATA_W-1:0] rdata;
        logic                     error;
        logic                     timeout;
    } apb_rsp_t;

endpackage : apb_i2c_pkg
`default_nettype wire

// File: rtl/apb_wait_timer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : apb_wait_timer
//  Description : Wait-state counter for the APB ACCESS phase. Cleared in
//                SETUP, incremented on every PREADY-low ACCESS cycle.
//                o_expire flags the increment that brings the count to
//                TIMEOUT, so the caller can leave ACCESS on that same cycle.
//                TIMEOUT = 0 disables expiry.
//  Ports       : clk, rst (async, active high)
//                i_clr    - clear the count to zero
//                i_inc    - count one wait cycle
//                o_expire - this increment reaches TIMEOUT
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_wait_timer #(
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_inc,
    output logic o_expire
);

    // One extra bit so the compare against TIMEOUT cannot alias on wrap.
    localparam logic [TO_W:0] C_LIMIT = (TO_W + 1)'(TIMEOUT);

    logic [TO_W-1:0] count_q;
    logic [TO_W-1:0] count_d;
    logic [TO_W:0]   w_count_inc;

    assign w_count_inc = {1'b0, count_q} + {{TO_W{1'b0}}, 1'b1};

    // Compare the post-increment value: the cycle that would make the count
    // equal TIMEOUT is the last ACCESS cycle.
    assign o_expire = (TIMEOUT != 0) && i_inc && (w_count_inc == C_LIMIT);

    always_comb begin
        count_d = count_q;
        if (i_clr) begin
            count_d = '0;
        end else if (i_inc) begin
            count_d = w_count_inc[TO_W-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : apb_wait_timer
`default_nettype wire

// File: rtl/apb_i2c_requester.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : apb_i2c_requester
//  Description : Turns a valid/ready command stream into single APB transfers
//                (SETUP then ACCESS) towards the APB-to-I2C core and returns
//                read data, PSLVERR and timeout status on a valid/ready
//                response stream. One transfer outstanding at a time; an
//                ACCESS phase that never sees PREADY is aborted after TIMEOUT
//                wait cycles.
//  Ports       : PCLK, PRESET (async, active high)
//                CMD_*  - command stream in (VALID/READY/WRITE/ADDR/WDATA)
//                RSP_*  - response stream out (VALID/READY/RDATA/ERROR/TIMEOUT)
//                P*     - APB requester port (PSELx/PENABLE/PWRITE/PADDR/
//                         PWDATA out, PRDATA/PREADY/PSLVERR in)
//  Revision    : 1.0 - initial release
// ============================================================================
module apb_i2c_requester #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic              PCLK,
    input  logic              PRESET,
    // command stream
    input  logic              CMD_VALID,
    output logic              CMD_READY,
    input  logic              CMD_WRITE,
    input  logic [ADDR_W-1:0] CMD_ADDR,
    input  logic [DATA_W-1:0] CMD_WDATA,
    // response stream
    output logic              RSP_VALID,
    input  logic              RSP_READY,
    output logic [DATA_W-1:0] RSP_RDATA,
    output logic              RSP_ERROR,
    output logic              RSP_TIMEOUT,
    // APB requester
    output logic              PSELx,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    import apb_i2c_pkg::*;

    apb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              pwrite_q, pwrite_d;
    apb_rsp_t          rsp_q, rsp_d;

    logic              w_timer_clr;
    logic              w_timer_inc;
    logic              w_timer_expire;

    apb_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wait_timer (
        .clk      (PCLK),
        .rst      (PRESET),
        .i_clr    (w_timer_clr),
        .i_inc    (w_timer_inc),
        .o_expire (w_timer_expire)
    );

    // ------------------------------------------------------------------
    // Next-state / datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        rsp_d       = rsp_q;
        w_timer_clr = 1'b0;
        w_timer_inc = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (CMD_VALID) begin
                    paddr_d  = CMD_ADDR;
                    pwdata_d = CMD_WDATA;
                    pwrite_d = CMD_WRITE;
                    state_d  = S_SETUP;
                end
            end

            S_SETUP: begin
                w_timer_clr = 1'b1;
                state_d     = S_ACCESS;
            end

            S_ACCESS: begin
                // PREADY is tested first so a completion on the cycle the
                // timer would expire is reported as a normal response.
                if (PREADY) begin
                    rsp_d.rdata   = pwrite_q ? '0 : C_RSP_RDATA_W'(PRDATA);
                    rsp_d.error   = PSLVERR;
                    rsp_d.timeout = 1'b0;
                    state_d       = S_RESP;
                end else begin
                    w_timer_inc = 1'b1;
                    if (w_timer_expire) begin
                        rsp_d.rdata   = '0;
                        rsp_d.error   = 1'b1;
                        rsp_d.timeout = 1'b1;
                        state_d       = S_RESP;
                    end
                end
            end

            S_RESP: begin
                if (RSP_READY) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q  <= S_IDLE;
            paddr_q  <= '0;
            pwdata_q <= '0;
            pwrite_q <= 1'b0;
            rsp_q    <= '0;
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            pwrite_q <= pwrite_d;
            rsp_q    <= rsp_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: bus strobes decode straight from the state register so an
    // asynchronous reset drops PSELx/PENABLE without waiting for a clock.
    // ------------------------------------------------------------------
    assign CMD_READY   = (state_q == S_IDLE);
    assign PSELx       = (state_q == S_SETUP) || (state_q == S_ACCESS);
    assign PENABLE     = (state_q == S_ACCESS);
    assign RSP_VALID   = (state_q == S_RESP);

    assign PADDR       = paddr_q;
    assign PWDATA      = pwdata_q;
    assign PWRITE      = pwrite_q;

    assign RSP_RDATA   = DATA_W'(rsp_q.rdata);
    assign RSP_ERROR   = rsp_q.error;
    assign RSP_TIMEOUT = rsp_q.timeout;

endmodule : apb_i2c_requester
`default_nettype wire

// File: tb/tb_apb_i2c_requester.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_apb_i2c_requester
//  Description : Self-checking bench for apb_i2c_requester. A small APB slave
//                model stands in for the I2C core (TX/RX/CONFIG/TIMEOUT
//                mapped, everything else never ready). Expected responses are
//                queued on command acceptance and compared when the response
//                handshake happens.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_i2c_requester;

    import apb_i2c_pkg::*;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;
    localparam int TO_W    = 8;

    localparam logic [31:0] C_RX_DATA = 32'hDEAD_BEEF;
    localparam logic [31:0] C_TX_DATA = 32'h1234_5678;

    // ------------------------------------------------------------------
    // DUT signals
    // ------------------------------------------------------------------
    logic              PCLK = 1'b0;
    logic              PRESET;
    logic              CMD_VALID, CMD_READY, CMD_WRITE;
    logic [ADDR_W-1:0] CMD_ADDR;
    logic [DATA_W-1:0] CMD_WDATA;
    logic              RSP_VALID, RSP_READY;
    logic [DATA_W-1:0] RSP_RDATA;
    logic              RSP_ERROR, RSP_TIMEOUT;
    logic              PSELx, PENABLE, PWRITE;
    logic [ADDR_W-1:0] PADDR;
    logic [DATA_W-1:0] PWDATA, PRDATA;
    logic              PREADY, PSLVERR;

    always #5 PCLK = ~PCLK;

    apb_i2c_requester #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .PCLK        (PCLK),
        .PRESET      (PRESET),
        .CMD_VALID   (CMD_VALID),
        .CMD_READY   (CMD_READY),
        .CMD_WRITE   (CMD_WRITE),
        .CMD_ADDR    (CMD_ADDR),
        .CMD_WDATA   (CMD_WDATA),
        .RSP_VALID   (RSP_VALID),
        .RSP_READY   (RSP_READY),
        .RSP_RDATA   (RSP_RDATA),
        .RSP_ERROR   (RSP_ERROR),
        .RSP_TIMEOUT (RSP_TIMEOUT),
        .PSELx       (PSELx),
        .PENABLE     (PENABLE),
        .PWRITE      (PWRITE),
        .PADDR       (PADDR),
        .PWDATA      (PWDATA),
        .PRDATA      (PRDATA),
        .PREADY      (PREADY),
        .PSLVERR     (PSLVERR)
    );

    // ------------------------------------------------------------------
    // Vector record and scoreboard
    // ------------------------------------------------------------------
    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        int unsigned waits;      // PREADY-low ACCESS cycles before ready
        logic        slverr;     // PSLVERR in the PREADY cycle
        logic        force_err;  // PSLVERR forced high in non-ready cycles
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic        exp_to;
        int unsigned exp_acc;    // expected number of ACCESS cycles
    } vec_t;

    vec_t     vecs[9];
    vec_t     cur;
    apb_rsp_t exp_q[$];
    apb_rsp_t mon_e;

    int n_vec  = 0;
    int n_miss = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // APB slave model of the I2C core
    // ------------------------------------------------------------------
    int unsigned cyc = 0;
    int unsigned acc_cnt;
    int unsigned cur_waits;
    logic        cur_slverr, cur_force;
    logic [31:0] cfg_reg;
    logic        mapped;

    always @(posedge PCLK) cyc <= cyc + 1;

    assign mapped = (PADDR == ADDR_W'(C_REG_TX))     || (PADDR == ADDR_W'(C_REG_RX)) ||
                    (PADDR == ADDR_W'(C_REG_CONFIG)) || (PADDR == ADDR_W'(C_REG_TIMEOUT));
    assign PREADY  = PSELx && PENABLE && mapped && (acc_cnt == cur_waits);
    assign PSLVERR = PREADY ? cur_slverr : cur_force;

    always_comb begin
        PRDATA = 32'hBAD0_0000 | cyc;   // junk outside the ready cycle
        if (PREADY) begin
            case (PADDR)
                ADDR_W'(C_REG_TX):     PRDATA = C_TX_DATA;
                ADDR_W'(C_REG_RX):     PRDATA = C_RX_DATA;
                ADDR_W'(C_REG_CONFIG): PRDATA = cfg_reg;
                default:               PRDATA = 32'hBAD1_0000;
            endcase
        end
    end

    always @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            acc_cnt <= 0;
            cfg_reg <= '0;
        end else begin
            if (PSELx && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
            else                             acc_cnt <= 0;
            if (PSELx && PENABLE && PREADY && PWRITE && PADDR == ADDR_W'(C_REG_CONFIG))
                cfg_reg <= PWDATA;
        end
    end

    // ------------------------------------------------------------------
    // Monitor: ACCESS-cycle count, bus stability, response scoreboard
    // ------------------------------------------------------------------
    int unsigned acc_seen = 0;
    logic        bus_bad  = 1'b0;

    always @(negedge PCLK) begin
        if (!PRESET) begin
            if (PSELx && !PENABLE) begin
                acc_seen = 0;
                bus_bad  = 1'b0;
            end
            if (PSELx && PENABLE) acc_seen++;
            if (PSELx && (PADDR != cur.addr || PWRITE != cur.write ||
                          (cur.write && PWDATA != cur.wdata)))
                bus_bad = 1'b1;
            if (RSP_VALID && RSP_READY) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 64'(RSP_VALID), 64'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_rdata",   64'(RSP_RDATA),   64'(mon_e.rdata));
                    chk("rsp_error",   64'(RSP_ERROR),   64'(mon_e.error));
                    chk("rsp_timeout", 64'(RSP_TIMEOUT), 64'(mon_e.timeout));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    task automatic step();
        @(posedge PCLK);
        #2;
    endtask

    task automatic set_vec(input vec_t v);
        cur        = v;
        cur_waits  = v.waits;
        cur_slverr = v.slverr;
        cur_force  = v.force_err;
        CMD_WRITE  = v.write;
        CMD_ADDR   = v.addr;
        CMD_WDATA  = v.wdata;
    endtask

    // Offer the command until accepted; queue its expected response.
    task automatic send_cmd(input vec_t v, output int unsigned acc_cyc);
        bit got = 0;
        acc_cyc = 0;
        set_vec(v);
        CMD_VALID = 1'b1;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge PCLK);
            if (CMD_READY) begin
                got     = 1;
                acc_cyc = cyc;
                exp_q.push_back('{rdata: v.exp_rdata, error: v.exp_err, timeout: v.exp_to});
            end
            step();
        end
        CMD_VALID = 1'b0;
        chk("cmd_accept", 64'(got), 64'd1);
    endtask

    // Bounded wait for RSP_VALID; returns the cycle it was first seen.
    task automatic wait_rsp(output bit got, output int unsigned rsp_cyc);
        got     = 0;
        rsp_cyc = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge PCLK);
            if (RSP_VALID) begin
                got     = 1;
                rsp_cyc = cyc;
            end
        end
        chk("rsp_seen", 64'(got), 64'd1);
    endtask

    task automatic run_vec(input vec_t v, output int unsigned acc_cyc);
        bit          got;
        int unsigned rsp_cyc;
        send_cmd(v, acc_cyc);
        wait_rsp(got, rsp_cyc);
        if (got) begin
            chk("latency",      64'(rsp_cyc - acc_cyc), 64'(2 + v.exp_acc));
            chk("access_count", 64'(acc_seen),          64'(v.exp_acc));
            chk("bus_idle_rsp", 64'({PSELx, PENABLE}),  64'd0);
            chk("bus_stable",   64'(bus_bad),           64'd0);
        end
        step();
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin : main
        int unsigned acc_cyc, hs_cyc, rsp_cyc;
        bit          got;
        vec_t        v;

        //          wr    addr   wdata         wt  serr frc  rdata         err  to   acc
        vecs[0] = '{1'b1, 32'h8, 32'h0000_2A5C, 0, 1'b0, 1'b0, 32'h0,        1'b0, 1'b0, 1};
        vecs[1] = '{1'b0, 32'h4, 32'h0,         0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1};
        vecs[2] = '{1'b0, 32'h8, 32'h0,         2, 1'b0, 1'b0, 32'h0000_2A5C, 1'b0, 1'b0, 3};
        vecs[3] = '{1'b0, 32'h10, 32'h0,        0, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 16};
        vecs[4] = '{1'b1, 32'h0, 32'h0000_00A5, 0, 1'b1, 1'b0, 32'h0,        1'b1, 1'b0, 1};
        vecs[5] = '{1'b0, 32'h4, 32'h0,        15, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 16};
        vecs[6] = '{1'b0, 32'h4, 32'h0,        16, 1'b0, 1'b0, 32'h0,        1'b1, 1'b1, 16};
        vecs[7] = '{1'b0, 32'h0, 32'h0,         3, 1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 4};
        vecs[8] = '{1'b1, 32'hC, 32'h0000_0005, 1, 1'b0, 1'b1, 32'h0,        1'b0, 1'b0, 2};

        PRESET     = 1'b1;
        CMD_VALID  = 1'b0;
        RSP_READY  = 1'b1;
        set_vec(vecs[0]);
        repeat (3) @(posedge PCLK);
        #2 PRESET = 1'b0;

        // reset state: only CMD_READY high
        @(negedge PCLK);
        chk("reset_state",
            64'({CMD_READY, RSP_VALID, PSELx, PENABLE, PWRITE, RSP_ERROR, RSP_TIMEOUT}),
            64'(7'b100_0000));
        chk("reset_data", 64'({PADDR, PWDATA | RSP_RDATA}), 64'd0);
        step();

        // table-driven transfers
        for (int i = 0; i < 9; i++) run_vec(vecs[i], acc_cyc);

        // backpressure: RSP_READY low for 10 cycles, next command waiting
        RSP_READY = 1'b0;
        send_cmd(vecs[1], acc_cyc);
        wait_rsp(got, rsp_cyc);
        chk("bp_latency", 64'(rsp_cyc - acc_cyc), 64'd3);
        v = '{1'b1, 32'h8, 32'h0000_0077, 0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1};
        CMD_VALID = 1'b1;
        CMD_WRITE = v.write;
        CMD_ADDR  = v.addr;
        CMD_WDATA = v.wdata;
        for (int i = 0; i < 10; i++) begin
            step();
            @(negedge PCLK);
            chk("bp_stall",
                64'({CMD_READY, PSELx, PENABLE, RSP_VALID, RSP_RDATA, RSP_ERROR, RSP_TIMEOUT}),
                64'({1'b0, 1'b0, 1'b0, 1'b1, C_RX_DATA, 1'b0, 1'b0}));
        end
        step();
        RSP_READY = 1'b1;
        @(negedge PCLK);
        hs_cyc = cyc;
        step();
        run_vec(v, acc_cyc);
        chk("bp_next_accept", 64'(acc_cyc - hs_cyc), 64'd1);

        // asynchronous reset while waiting in ACCESS
        send_cmd(vecs[3], acc_cyc);
        repeat (5) @(negedge PCLK);
        #1 PRESET = 1'b1;
        #1;
        chk("reset_drops_bus", 64'({PSELx, PENABLE}), 64'd0);
        exp_q.delete();
        step();
        step();
        PRESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge PCLK);
            chk("post_reset_idle", 64'({RSP_VALID, CMD_READY, PSELx}), 64'(3'b010));
            step();
        end
        run_vec(vecs[1], acc_cyc);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_apb_i2c_requester
`default_nettype wire
